// File: rtl/image_ram_sequencer_pkg.sv
// image_pkg: constants shared by the image RAM sequencer and the training core.
//   Widths and depth of the training image RAM, field positions inside a row
//   (pixels on top, one-hot label in the low bits), and the sequencer FSM encoding.
package image_pkg;

   localparam int ADDR_WIDTH  = 16;
   localparam int DATA_WIDTH  = 794;
   localparam int DEPTH       = 60000;
   localparam int PIX_WIDTH   = 784;
   localparam int LABEL_WIDTH = 10;
   localparam int EPOCH_WIDTH = 8;

   // Row layout: {pixels[783:0], label[9:0]}
   localparam int LABEL_LSB = 0;
   localparam int LABEL_MSB = LABEL_WIDTH - 1;
   localparam int PIX_LSB   = LABEL_WIDTH;
   localparam int PIX_MSB   = DATA_WIDTH - 1;

   localparam int STATE_WIDTH = 2;
   localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_WIDTH-1:0] ST_FETCH   = 2'd1;
   localparam logic [STATE_WIDTH-1:0] ST_PRESENT = 2'd2;

endpackage

// File: rtl/image_ram_sequencer_if.sv
// image_ram_sequencer_if: sample stream from the sequencer to the training core.
//   out_valid   : sample available (master -> slave)
//   out_ready   : consumer accepts the sample (slave -> master)
//   out_pixels  : pixel field of the current row
//   out_label   : one-hot label field of the current row
//   out_index   : row index of the current sample
interface image_ram_sequencer_if;
   import image_pkg::*;

   logic                   out_valid;
   logic                   out_ready;
   logic [PIX_WIDTH-1:0]   out_pixels;
   logic [LABEL_WIDTH-1:0] out_label;
   logic [ADDR_WIDTH-1:0]  out_index;

   modport master (
      output out_valid, out_pixels, out_label, out_index,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_pixels, out_label, out_index,
      output out_ready
   );

endinterface

// File: rtl/image_ram_sequencer_onehot_check.sv
// onehot_check: combinational test that exactly one bit of value is set.
//   value     : vector under test
//   is_onehot : 1 iff exactly one bit of value is 1
module onehot_check #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] value,
   output logic             is_onehot
);

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign is_onehot = (value != '0) && ((value & (value - WIDTH'(1))) == '0);

endmodule

// File: rtl/image_ram_sequencer.sv
// image_ram_sequencer: walks the training image RAM row by row for a programmable
// number of epochs and streams each row as pixels + one-hot label.
//   clk, rst          : clock and synchronous active-high reset
//   start, abort      : begin a run (sampled in IDLE) / terminate a run
//   num_epochs        : epochs per run, latched at start
//   num_samples       : rows per epoch (1..DEPTH), latched at start
//   ram_en/we/addr    : image RAM control (read only, 1-cycle registered read)
//   ram_dout          : image RAM read data, held by the RAM while en=0
//   smp               : sample stream (valid/ready, pixels, label, index)
//   epoch             : current epoch, 0-based
//   busy              : run in progress
//   epoch_done, done  : one-cycle pulses at end of epoch / end of run
//   label_err         : sticky, a delivered label was not one-hot
module image_ram_sequencer
   import image_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [EPOCH_WIDTH-1:0] num_epochs,
   input  logic [ADDR_WIDTH-1:0]  num_samples,
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   input  logic [DATA_WIDTH-1:0]  ram_dout,
   image_ram_sequencer_if.master  smp,
   output logic [EPOCH_WIDTH-1:0] epoch,
   output logic                   busy,
   output logic                   epoch_done,
   output logic                   done,
   output logic                   label_err
);

   logic [STATE_WIDTH-1:0] state_reg;
   logic [ADDR_WIDTH-1:0]  idx_reg;
   logic [EPOCH_WIDTH-1:0] epoch_reg;
   logic [EPOCH_WIDTH-1:0] num_epochs_reg;
   logic [ADDR_WIDTH-1:0]  num_samples_reg;
   logic                   epoch_done_reg;
   logic                   done_reg;
   logic                   label_err_reg;

   logic                   label_ok;
   logic                   in_present;
   logic                   transfer;
   logic                   last_sample;
   logic                   last_epoch;

   onehot_check #(
      .WIDTH (LABEL_WIDTH)
   ) u_onehot_check (
      .value     (smp.out_label),
      .is_onehot (label_ok)
   );

   assign in_present  = (state_reg == ST_PRESENT);
   assign transfer    = in_present && smp.out_ready;
   assign last_sample = (idx_reg == num_samples_reg - ADDR_WIDTH'(1));
   assign last_epoch  = (epoch_reg == num_epochs_reg - EPOCH_WIDTH'(1));

   // RAM is read only from here; the address simply follows the row counter and
   // only matters while en is high in FETCH.
   assign ram_en   = (state_reg == ST_FETCH);
   assign ram_we   = 1'b0;
   assign ram_addr = idx_reg;

   // Data path is straight from the RAM output: the RAM holds dout while en=0,
   // so the fields stay stable for the whole PRESENT window.
   assign smp.out_valid  = in_present;
   assign smp.out_pixels = ram_dout[PIX_MSB:PIX_LSB];
   assign smp.out_label  = ram_dout[LABEL_MSB:LABEL_LSB];
   assign smp.out_index  = idx_reg;

   assign epoch      = epoch_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign epoch_done = epoch_done_reg;
   assign done       = done_reg;
   // Flag is visible from the first PRESENT cycle of a bad row and then held.
   assign label_err  = label_err_reg || (in_present && !label_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         epoch_reg       <= '0;
         num_epochs_reg  <= '0;
         num_samples_reg <= '0;
         epoch_done_reg  <= 1'b0;
         done_reg        <= 1'b0;
         label_err_reg   <= 1'b0;
      end else begin
         epoch_done_reg <= 1'b0;
         done_reg       <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (num_epochs == '0 || num_samples == '0) begin
                     // Empty run: report completion without touching the RAM.
                     done_reg <= 1'b1;
                  end else begin
                     num_epochs_reg  <= num_epochs;
                     num_samples_reg <= num_samples;
                     idx_reg         <= '0;
                     epoch_reg       <= '0;
                     label_err_reg   <= 1'b0;
                     state_reg       <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               state_reg <= abort ? ST_IDLE : ST_PRESENT;
            end
            ST_PRESENT: begin
               if (!label_ok) begin
                  label_err_reg <= 1'b1;
               end
               if (abort) begin
                  // A coincident transfer is accepted by the consumer, but the
                  // run ends here with no completion pulses.
                  state_reg <= ST_IDLE;
               end else if (transfer) begin
                  if (!last_sample) begin
                     idx_reg   <= idx_reg + ADDR_WIDTH'(1);
                     state_reg <= ST_FETCH;
                  end else begin
                     idx_reg        <= '0;
                     epoch_done_reg <= 1'b1;
                     if (last_epoch) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                     end else begin
                        epoch_reg <= epoch_reg + EPOCH_WIDTH'(1);
                        state_reg <= ST_FETCH;
                     end
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_ram_sequencer.sv
// Testbench for image_ram_sequencer: directed runs with a scoreboard of expected
// samples consumed by a monitor on every accepted transfer.
module tb_image_ram_sequencer;
   import image_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   start = 1'b0;
   logic                   abort = 1'b0;
   logic [EPOCH_WIDTH-1:0] num_epochs = '0;
   logic [ADDR_WIDTH-1:0]  num_samples = '0;
   logic                   ram_en;
   logic                   ram_we;
   logic [ADDR_WIDTH-1:0]  ram_addr;
   logic [DATA_WIDTH-1:0]  ram_dout = '0;
   logic [EPOCH_WIDTH-1:0] epoch;
   logic                   busy;
   logic                   epoch_done;
   logic                   done;
   logic                   label_err;

   image_ram_sequencer_if smp ();

   image_ram_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .num_epochs  (num_epochs),
      .num_samples (num_samples),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_dout    (ram_dout),
      .smp         (smp),
      .epoch       (epoch),
      .busy        (busy),
      .epoch_done  (epoch_done),
      .done        (done),
      .label_err   (label_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ed_cnt = 0;
   int d_cnt = 0;
   int both_cnt = 0;

   // Image RAM contents: pixel pattern per row plus a label table the bench edits.
   logic [LABEL_WIDTH-1:0] lab [16];

   function automatic logic [PIX_WIDTH-1:0] pix_of(input int i);
      logic [PIX_WIDTH-1:0] p;
      for (int k = 0; k < 49; k++) begin
         p[k*16 +: 16] = 16'(i * 16'h1357 + k * 16'h00A1 + 16'h5A5A);
      end
      return p;
   endfunction

   always @(posedge clk) begin
      if (ram_en) begin
         ram_dout <= {pix_of(int'(ram_addr)), lab[ram_addr[3:0]]};
      end
   end

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  idx;
      logic [EPOCH_WIDTH-1:0] ep;
      logic                   lerr;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int i, input int e, input logic l);
      exp_t x;
      x.idx  = ADDR_WIDTH'(i);
      x.ep   = EPOCH_WIDTH'(e);
      x.lerr = l;
      exp_q.push_back(x);
   endtask

   // Monitor: every accepted transfer is checked against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && smp.out_valid && smp.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample actual=index %0d required=no sample", smp.out_index);
         end else begin
            mon_e = exp_q.pop_front();
            $display("sample index=%0d epoch=%0d label=%b label_err=%0b",
                     smp.out_index, epoch, smp.out_label, label_err);
            chk("sample_index", 64'(smp.out_index), 64'(mon_e.idx));
            chk("sample_epoch", 64'(epoch), 64'(mon_e.ep));
            chk("sample_label", 64'(smp.out_label), 64'(lab[mon_e.idx[3:0]]));
            chk("sample_label_err", 64'(label_err), 64'(mon_e.lerr));
            chk("sample_ram_en", 64'(ram_en), 64'd0);
            checks++;
            if (smp.out_pixels !== pix_of(int'(mon_e.idx))) begin
               errors++;
               $display("FAIL sample_pixels index %0d actual=%h required=%h",
                        mon_e.idx, smp.out_pixels[63:0], pix_of(int'(mon_e.idx)) & 784'hFFFFFFFFFFFFFFFF);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (epoch_done) ed_cnt++;
      if (done) d_cnt++;
      if (done && epoch_done) both_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int ep, input int ns);
      num_epochs  = EPOCH_WIDTH'(ep);
      num_samples = ADDR_WIDTH'(ns);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid;
      for (int n = 0; n < 20; n++) begin
         if (smp.out_valid) break;
         tick();
      end
      chk("wait_valid_timeout", 64'(smp.out_valid), 64'd1);
   endtask

   task automatic accept;
      wait_valid();
      smp.out_ready = 1'b1;
      tick();
      smp.out_ready = 1'b0;
   endtask

   task automatic wait_idle;
      for (int n = 0; n < 60; n++) begin
         if (!busy) break;
         tick();
      end
      chk("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   int d_snap, ed_snap, both_snap;

   initial begin
      smp.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) lab[i] = LABEL_WIDTH'(1) << (i % 10);

      // Reset state
      tick(); tick(); tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(smp.out_valid), 64'd0);
      chk("rst_ram_en", 64'(ram_en), 64'd0);
      chk("rst_ram_we", 64'(ram_we), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_epoch", 64'(epoch), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_label_err", 64'(label_err), 64'd0);
      rst = 1'b0;
      tick();

      // T1: 1 epoch x 4 samples, ready always high; exact cycle timing
      smp.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(i, 0, 1'b0);
      do_start(1, 4);
      for (int k = 1; k <= 9; k++) begin
         if (k <= 8) begin
            chk("t1_valid", 64'(smp.out_valid), 64'(k % 2 == 0));
            chk("t1_busy", 64'(busy), 64'd1);
            chk("t1_done_early", 64'(done), 64'd0);
         end
         if (k % 2 == 1 && k <= 7) begin
            chk("t1_ram_en", 64'(ram_en), 64'd1);
            chk("t1_ram_addr", 64'(ram_addr), 64'((k - 1) / 2));
         end
         if (k == 9) begin
            chk("t1_done", 64'(done), 64'd1);
            chk("t1_epoch_done", 64'(epoch_done), 64'd1);
            chk("t1_busy_end", 64'(busy), 64'd0);
         end
         if (k < 9) tick();
      end
      smp.out_ready = 1'b0;
      tick();
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // T2: 3 epochs x 2 samples
      d_snap = d_cnt; ed_snap = ed_cnt; both_snap = both_cnt;
      smp.out_ready = 1'b1;
      for (int e = 0; e < 3; e++) begin
         push_exp(0, e, 1'b0);
         push_exp(1, e, 1'b0);
      end
      do_start(3, 2);
      wait_idle();
      smp.out_ready = 1'b0;
      tick();
      chk("t2_epoch_done_count", 64'(ed_cnt - ed_snap), 64'd3);
      chk("t2_done_count", 64'(d_cnt - d_snap), 64'd1);
      chk("t2_done_with_epoch_done", 64'(both_cnt - both_snap), 64'd1);
      chk("t2_final_epoch", 64'(epoch), 64'd2);
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // T3: consumer stalls 5 cycles on the first sample
      for (int i = 0; i < 3; i++) push_exp(i, 0, 1'b0);
      do_start(1, 3);
      wait_valid();
      for (int c = 0; c < 5; c++) begin
         chk("t3_stall_valid", 64'(smp.out_valid), 64'd1);
         chk("t3_stall_index", 64'(smp.out_index), 64'd0);
         chk("t3_stall_label", 64'(smp.out_label), 64'(lab[0]));
         checks++;
         if (smp.out_pixels !== pix_of(0)) begin
            errors++;
            $display("FAIL t3_stall_pixels actual=%h required=%h",
                     smp.out_pixels[63:0], pix_of(0) & 784'hFFFFFFFFFFFFFFFF);
         end
         chk("t3_stall_ram_en", 64'(ram_en), 64'd0);
         tick();
      end
      smp.out_ready = 1'b1;
      tick();
      smp.out_ready = 1'b0;
      chk("t3_next_fetch_en", 64'(ram_en), 64'd1);
      chk("t3_next_fetch_addr", 64'(ram_addr), 64'd1);
      chk("t3_next_fetch_valid", 64'(smp.out_valid), 64'd0);
      accept();
      accept();
      wait_idle();
      chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // T4: bad labels (two bits set, then no bit set) on row 5
      lab[5] = 10'b0000000011;
      smp.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_exp(i, 0, i == 5);
      do_start(1, 6);
      wait_idle();
      smp.out_ready = 1'b0;
      tick(); tick();
      chk("t4_label_err_sticky", 64'(label_err), 64'd1);
      lab[5] = 10'b0000000000;
      smp.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_exp(i, 0, i == 5);
      do_start(1, 6);
      chk("t4_label_err_cleared", 64'(label_err), 64'd0);
      wait_idle();
      smp.out_ready = 1'b0;
      tick();
      chk("t4_label_err_zero_label", 64'(label_err), 64'd1);
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      lab[5] = 10'b0000100000;

      // T5: abort mid-epoch, then empty runs
      for (int i = 0; i < 3; i++) push_exp(i, 0, 1'b0);
      do_start(2, 10);
      chk("t5_label_err_cleared", 64'(label_err), 64'd0);
      for (int i = 0; i < 3; i++) accept();
      wait_valid();
      chk("t5_index_at_abort", 64'(smp.out_index), 64'd3);
      d_snap = d_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort_busy", 64'(busy), 64'd0);
      chk("t5_abort_valid", 64'(smp.out_valid), 64'd0);
      chk("t5_abort_ram_en", 64'(ram_en), 64'd0);
      tick(); tick(); tick();
      chk("t5_abort_no_done", 64'(d_cnt - d_snap), 64'd0);
      ed_snap = ed_cnt;
      do_start(0, 5);
      chk("t5_zero_epochs_done", 64'(done), 64'd1);
      chk("t5_zero_epochs_busy", 64'(busy), 64'd0);
      tick();
      chk("t5_zero_epochs_done_pulse", 64'(done), 64'd0);
      do_start(2, 0);
      chk("t5_zero_samples_done", 64'(done), 64'd1);
      chk("t5_zero_samples_busy", 64'(busy), 64'd0);
      tick();
      chk("t5_zero_no_epoch_done", 64'(ed_cnt - ed_snap), 64'd0);
      chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      // T6: start while busy is ignored, then reset in PRESENT at idx 7
      for (int i = 0; i < 7; i++) push_exp(i, 0, 1'b0);
      do_start(1, 10);
      accept();
      accept();
      num_epochs  = 8'd1;
      num_samples = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 2; i < 7; i++) accept();
      wait_valid();
      chk("t6_index_before_rst", 64'(smp.out_index), 64'd7);
      chk("t6_busy_before_rst", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_valid", 64'(smp.out_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_ram_en", 64'(ram_en), 64'd0);
      chk("t6_rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("t6_rst_index", 64'(smp.out_index), 64'd0);
      chk("t6_rst_epoch", 64'(epoch), 64'd0);
      chk("t6_rst_done", 64'(done), 64'd0);
      chk("t6_rst_epoch_done", 64'(epoch_done), 64'd0);
      chk("t6_rst_label_err", 64'(label_err), 64'd0);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
